// File: rtl/rf_cmd_ctrl.sv
// Byte-command initiator for the configuration register file: UART RX frames -> RF strobes, RF read data -> UART TX.
// Optional macro RF_CMD_WR_ACK_EN: after each write, send an 8'h5A acknowledge byte on the TX path.
module rf_cmd_ctrl #(
   parameter int unsigned           ADDR_SIZE  = 4,
   parameter int unsigned           DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
   parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB,
   parameter int unsigned           RD_TIMEOUT = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   output logic                  WrEn,
   output logic                  RdEn,
   output logic [ADDR_SIZE-1:0]  Address,
   output logic [DATA_WIDTH-1:0] WrData,
   input  logic [DATA_WIDTH-1:0] RdData,
   input  logic                  RdData_valid,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_D_VLD,
   input  logic                  TX_BUSY,
   output logic                  Cmd_Err
);

   localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);
`ifdef RF_CMD_WR_ACK_EN
   localparam logic [DATA_WIDTH-1:0] ACK_BYTE = DATA_WIDTH'(8'h5A);
`endif

   typedef enum logic [2:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND, WR_ACK
   } state_t;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic                  wr_en_nxt, rd_en_nxt, err_nxt, tx_vld_nxt;
   logic [ADDR_SIZE-1:0]  addr_nxt;
   logic [DATA_WIDTH-1:0] wr_data_nxt, tx_data_nxt;
   logic                  addr_ok_c, is_wr_c, is_rd_c, rd_last_c;

   // Upper bits of an address byte must be zero to be a legal register index.
   assign addr_ok_c = (RX_P_DATA[DATA_WIDTH-1:ADDR_SIZE] == '0);
   assign is_wr_c   = (RX_P_DATA == WR_CMD);
   assign is_rd_c   = (RX_P_DATA == RD_CMD);
   assign rd_last_c = (cnt == CNT_W'(RD_TIMEOUT - 1));

   // State and timeout counter register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state and read-timeout counter
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      case (state)
         IDLE: begin
            if (RX_D_VLD && is_wr_c)      state_nxt = WR_ADDR;
            else if (RX_D_VLD && is_rd_c) state_nxt = RD_ADDR;
         end
         WR_ADDR: if (RX_D_VLD) state_nxt = addr_ok_c ? WR_DATA : IDLE;
`ifdef RF_CMD_WR_ACK_EN
         WR_DATA: if (RX_D_VLD) state_nxt = WR_ACK;
         WR_ACK:  if (TX_D_VLD && !TX_BUSY) state_nxt = IDLE;
`else
         WR_DATA: if (RX_D_VLD) state_nxt = IDLE;
`endif
         RD_ADDR: if (RX_D_VLD) state_nxt = addr_ok_c ? RD_WAIT : IDLE;
         RD_WAIT: begin
            if (RdData_valid)   state_nxt = TX_SEND;
            else if (rd_last_c) state_nxt = IDLE;
            else                cnt_nxt   = cnt + CNT_W'(1);
         end
         TX_SEND: if (!TX_BUSY) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs; strobes and error default low every cycle.
   always_comb begin
      wr_en_nxt   = 1'b0;
      rd_en_nxt   = 1'b0;
      err_nxt     = 1'b0;
      addr_nxt    = Address;
      wr_data_nxt = WrData;
      tx_data_nxt = TX_P_DATA;
      tx_vld_nxt  = TX_D_VLD;
      case (state)
         IDLE: if (RX_D_VLD && !is_wr_c && !is_rd_c) err_nxt = 1'b1;
         WR_ADDR: begin
            if (RX_D_VLD) begin
               if (addr_ok_c) addr_nxt = RX_P_DATA[ADDR_SIZE-1:0];
               else           err_nxt  = 1'b1;
            end
         end
         WR_DATA: begin
            if (RX_D_VLD) begin
               wr_data_nxt = RX_P_DATA;
               wr_en_nxt   = 1'b1;
            end
         end
         RD_ADDR: begin
            if (RX_D_VLD) begin
               if (addr_ok_c) begin
                  addr_nxt  = RX_P_DATA[ADDR_SIZE-1:0];
                  rd_en_nxt = 1'b1;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         RD_WAIT: begin
            if (RdData_valid) begin
               tx_data_nxt = RdData;
               tx_vld_nxt  = 1'b1;
            end else if (rd_last_c) begin
               err_nxt = 1'b1;
            end
            if (RX_D_VLD) err_nxt = 1'b1;
         end
         TX_SEND: begin
            if (!TX_BUSY) tx_vld_nxt = 1'b0;
            if (RX_D_VLD) err_nxt = 1'b1;
         end
`ifdef RF_CMD_WR_ACK_EN
         // First WR_ACK cycle is the WrEn cycle; the ack byte is raised after it.
         WR_ACK: begin
            if (!TX_D_VLD) begin
               tx_vld_nxt  = 1'b1;
               tx_data_nxt = ACK_BYTE;
            end else if (!TX_BUSY) begin
               tx_vld_nxt = 1'b0;
            end
            if (RX_D_VLD) err_nxt = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // Output registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         WrEn      <= 1'b0;
         RdEn      <= 1'b0;
         Cmd_Err   <= 1'b0;
         Address   <= '0;
         WrData    <= '0;
         TX_P_DATA <= '0;
         TX_D_VLD  <= 1'b0;
      end else begin
         WrEn      <= wr_en_nxt;
         RdEn      <= rd_en_nxt;
         Cmd_Err   <= err_nxt;
         Address   <= addr_nxt;
         WrData    <= wr_data_nxt;
         TX_P_DATA <= tx_data_nxt;
         TX_D_VLD  <= tx_vld_nxt;
      end
   end

endmodule

// File: doc/rf_cmd_ctrl.md
Name: rf_cmd_ctrl

Overview:
- Command-side initiator for the configuration register file.
- Parses byte commands from the UART receive path into single-cycle register-file write and read strobes.
- Captures returned read data and hands it to the UART transmit path with a valid/busy handshake.
- Sits between UART RX/TX and the register file in the reference clock domain.

Parameters:
ADDR_SIZE, 4, register file address width; file depth is 2^ADDR_SIZE
DATA_WIDTH, 8, register and UART byte width
WR_CMD, 8'hAA, opcode for write frame: opcode, address, data
RD_CMD, 8'hBB, opcode for read frame: opcode, address
RD_TIMEOUT, 4, cycles waited in RD_WAIT for RdData_valid before abort (min 2)

Ports:
CLK  input  1  reference clock
RST  input  1  asynchronous active-low reset
RX_P_DATA  input  DATA_WIDTH  received byte
RX_D_VLD  input  1  one-cycle pulse, RX_P_DATA valid
WrEn  output  1  register file write strobe
RdEn  output  1  register file read strobe
Address  output  ADDR_SIZE  register file address
WrData  output  DATA_WIDTH  register file write data
RdData  input  DATA_WIDTH  register file read data
RdData_valid  input  1  read data valid, one cycle after RdEn
TX_P_DATA  output  DATA_WIDTH  byte to transmit
TX_D_VLD  output  1  TX_P_DATA valid, held until accepted
TX_BUSY  input  1  transmitter busy; byte accepted when TX_D_VLD=1 and TX_BUSY=0
Cmd_Err  output  1  one-cycle pulse on a malformed or aborted command

Behaviour:
- Reset (RST low, asynchronous):
  - All outputs 0; state IDLE; timeout counter 0.
  - Reset mid-frame or mid-handshake aborts immediately; no partial strobe is ever issued.
- All outputs are registered.
- State IDLE, on RX_D_VLD:
  - RX_P_DATA == WR_CMD -> WR_ADDR.
  - RX_P_DATA == RD_CMD -> RD_ADDR.
  - Any other byte -> stay IDLE, pulse Cmd_Err.
- State WR_ADDR, on RX_D_VLD:
  - If RX_P_DATA[7:ADDR_SIZE] != 0 -> IDLE, pulse Cmd_Err.
  - Else latch Address = RX_P_DATA[ADDR_SIZE-1:0] -> WR_DATA.
- State WR_DATA, on RX_D_VLD:
  - Latch WrData = RX_P_DATA.
  - Assert WrEn for exactly 1 cycle, starting the cycle after the data byte.
  - -> IDLE (or WR_ACK, see Optional Feature).
- State RD_ADDR, on RX_D_VLD:
  - Apply the same range check as WR_ADDR; on failure -> IDLE, pulse Cmd_Err.
  - Else latch Address, assert RdEn for exactly 1 cycle (the next cycle) -> RD_WAIT.
- RdEn and WrEn are never high together. Address is stable for the whole strobe cycle and holds its value until the next command.
- State RD_WAIT:
  - On RdData_valid: capture RdData into TX_P_DATA, set TX_D_VLD=1 next cycle -> TX_SEND.
  - The counter increments each cycle. Reaching RD_TIMEOUT without RdData_valid -> IDLE, pulse Cmd_Err.
- State TX_SEND:
  - Hold TX_D_VLD and TX_P_DATA stable.
  - In the first cycle with TX_BUSY=0, the byte is accepted; TX_D_VLD drops next cycle -> IDLE.
- RX_D_VLD arriving in RD_WAIT or TX_SEND: byte dropped, Cmd_Err pulses; the current operation continues unaffected.
- Normal latencies:
  - Write: WrEn rises 1 cycle after the data byte pulse.
  - Read: RdEn rises 1 cycle after the address byte pulse; TX_D_VLD rises 1 cycle after RdData_valid.
- Back-to-back commands: a new opcode is accepted in the first IDLE cycle; no dead cycles are required beyond the FSM return.

Optional Feature:
- Macro: RF_CMD_WR_ACK_EN.
- Defined:
  - After the WrEn cycle, the FSM enters WR_ACK.
  - It drives TX_P_DATA=8'h5A, TX_D_VLD=1, using the same handshake as TX_SEND, then -> IDLE.
  - RX bytes arriving in WR_ACK are dropped with Cmd_Err.
- Undefined: WR_DATA returns directly to IDLE; writes produce no TX traffic.

Test Plan:
- Reset values: hold RST low with random inputs -> all outputs 0. Release RST -> FSM in IDLE, no strobes.
- Write: pulses AA, 03, 21 -> one-cycle WrEn with Address=3, WrData=8'h21, one cycle after the 21 pulse. Without the macro: no TX_D_VLD. With the macro: TX_P_DATA=8'h5A handshake.
- Read: pulses BB, 02 -> one-cycle RdEn with Address=2. Model returns 8'h81 with RdData_valid next cycle -> TX_P_DATA=8'h81, TX_D_VLD=1. Hold TX_BUSY=1 for 5 cycles -> TX_D_VLD stays high, data stable, drops one cycle after TX_BUSY=0.
- Errors:
  - Opcode 8'h11 -> Cmd_Err pulse, stay IDLE.
  - AA, 8'h13 -> Cmd_Err pulse, no WrEn.
  - Read with no RdData_valid -> Cmd_Err pulse after 4 cycles, IDLE.
- Collision: during TX_SEND (TX_BUSY=1) pulse RX byte 8'hAA -> Cmd_Err pulse, pending byte still sent. The next command, BB 00, completes normally.
- Reset mid-op: assert RST while in RD_WAIT and again while TX_D_VLD=1 -> outputs 0 immediately (asynchronous). No RdEn or WrEn after release until a new full frame is received.
